// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - two-requester writeback arbiter for the register_file write port
// Optional REGFILE_WB_STATS_EN adds stats_clr / conflict_cnt.
module regfile_wb_arbiter #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [AW-1:0]     req0_addr,
    input  logic [DW-1:0]     req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [AW-1:0]     req1_addr,
    input  logic [DW-1:0]     req1_data,
    output logic              WE3,
    output logic [AW-1:0]     A3,
    output logic [DW-1:0]     WD3,
    output logic [2**AW-1:0]  pend_mask,
`ifdef REGFILE_WB_STATS_EN
    input  logic              stats_clr,
    output logic [15:0]       conflict_cnt,
`endif
    output logic              busy
);

    logic [1:0]    hold_v_q, hold_v_d;
    logic [AW-1:0] hold_addr_q [2];
    logic [AW-1:0] hold_addr_d [2];
    logic [DW-1:0] hold_data_q [2];
    logic [DW-1:0] hold_data_d [2];
    logic          last_grant_q, last_grant_d;
    logic          older_q, older_d;

    logic [1:0]    req_v;
    logic [AW-1:0] req_addr [2];
    logic [DW-1:0] req_data [2];
    logic          both_v, same_addr, gnt_any, gnt_idx, wr_en;
    logic [1:0]    gnt, ready, xfer, fill, stay;

    always_comb begin
        req_v       = {req1_valid, req0_valid};
        req_addr[0] = req0_addr;
        req_addr[1] = req1_addr;
        req_data[0] = req0_data;
        req_data[1] = req1_data;

        both_v    = &hold_v_q;
        same_addr = (hold_addr_q[0] == hold_addr_q[1]);
        gnt_any   = |hold_v_q;
        // Same destination must drain oldest-first; otherwise alternate.
        if (both_v)
            gnt_idx = same_addr ? older_q : !last_grant_q;
        else
            gnt_idx = hold_v_q[1];
        gnt = gnt_any ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;

        ready = ~hold_v_q | gnt;
        xfer  = req_v & ready;
        fill  = '0;
        for (int i = 0; i < 2; i++)
            fill[i] = xfer[i] && (req_addr[i] != '0);
        stay  = hold_v_q & ~gnt;
    end

    always_comb begin
        hold_v_d = fill | stay;
        for (int i = 0; i < 2; i++) begin
            hold_addr_d[i] = fill[i] ? req_addr[i] : hold_addr_q[i];
            hold_data_d[i] = fill[i] ? req_data[i] : hold_data_q[i];
        end
        last_grant_d = gnt_any ? gnt_idx : last_grant_q;

        // A reloaded hold is younger than one that stays put.
        if (fill[0] && fill[1])
            older_d = 1'b0;
        else if (fill[0] && stay[1])
            older_d = 1'b1;
        else if (fill[1] && stay[0])
            older_d = 1'b0;
        else
            older_d = older_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_v_q       <= '0;
            hold_addr_q[0] <= '0;
            hold_addr_q[1] <= '0;
            hold_data_q[0] <= '0;
            hold_data_q[1] <= '0;
            last_grant_q   <= 1'b1;
            older_q        <= 1'b0;
        end else begin
            hold_v_q       <= hold_v_d;
            hold_addr_q[0] <= hold_addr_d[0];
            hold_addr_q[1] <= hold_addr_d[1];
            hold_data_q[0] <= hold_data_d[0];
            hold_data_q[1] <= hold_data_d[1];
            last_grant_q   <= last_grant_d;
            older_q        <= older_d;
        end
    end

    // Held writes are discarded by reset, so none may reach the file during it.
    assign wr_en      = gnt_any && !rst;
    assign WE3        = wr_en;
    assign A3         = wr_en ? hold_addr_q[gnt_idx] : '0;
    assign WD3        = wr_en ? hold_data_q[gnt_idx] : '0;
    assign req0_ready = ready[0];
    assign req1_ready = ready[1];
    assign busy       = gnt_any;

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < 2; i++)
            if (hold_v_q[i])
                pend_mask[hold_addr_q[i]] = 1'b1;
    end

`ifdef REGFILE_WB_STATS_EN
    logic [15:0] conflict_cnt_q;

    always_ff @(posedge clk) begin
        if (rst || stats_clr)
            conflict_cnt_q <= '0;
        else if (both_v && (conflict_cnt_q != 16'hFFFF))
            conflict_cnt_q <= conflict_cnt_q + 16'd1;
    end

    assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_data, req1_data;
    logic          WE3;
    logic [AW-1:0] A3;
    logic [DW-1:0] WD3;
    logic [31:0]   pend_mask;
    logic          busy;
`ifdef REGFILE_WB_STATS_EN
    logic          stats_clr;
    logic [15:0]   conflict_cnt;
`endif

    regfile_wb_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
        .WE3(WE3), .A3(A3), .WD3(WD3), .pend_mask(pend_mask),
`ifdef REGFILE_WB_STATS_EN
        .stats_clr(stats_clr), .conflict_cnt(conflict_cnt),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: each slot carries an acceptance timestamp for age ordering.
    logic          mv [2];
    logic [AW-1:0] ma [2];
    logic [DW-1:0] md [2];
    int            mseq [2];
    int            seq_ctr;
    logic          mlast;
    logic          acc0, acc1;

    logic          e_any, e_gi, e_we, e_busy;
    logic [AW-1:0] e_a3;
    logic [DW-1:0] e_wd3;
    logic [31:0]   e_pend;
    logic          e_rdy [2];

    function automatic void model_eval();
        e_any = mv[0] || mv[1];
        if (mv[0] && mv[1]) begin
            if (ma[0] == ma[1]) e_gi = (mseq[0] < mseq[1]) ? 1'b0 : 1'b1;
            else                e_gi = ~mlast;
        end else begin
            e_gi = mv[1];
        end
        e_we   = e_any;
        e_a3   = e_any ? ma[e_gi] : '0;
        e_wd3  = e_any ? md[e_gi] : '0;
        e_busy = e_any;
        e_pend = '0;
        for (int k = 0; k < 2; k++)
            if (mv[k]) e_pend = e_pend | (32'd1 << ma[k]);
        e_rdy[0] = !mv[0] || (e_any && e_gi == 1'b0);
        e_rdy[1] = !mv[1] || (e_any && e_gi == 1'b1);
    endfunction

    function automatic void model_advance();
        model_eval();
        if (rst) begin
            mv[0] = 1'b0; mv[1] = 1'b0; mlast = 1'b1; seq_ctr = 0;
            acc0 = 1'b0; acc1 = 1'b0;
        end else begin
            acc0 = req0_valid && e_rdy[0];
            acc1 = req1_valid && e_rdy[1];
            if (e_any) begin
                mv[e_gi] = 1'b0;
                mlast    = e_gi;
            end
            if (acc0 && req0_addr != '0) begin
                mv[0] = 1'b1; ma[0] = req0_addr; md[0] = req0_data; mseq[0] = seq_ctr; seq_ctr++;
            end
            if (acc1 && req1_addr != '0) begin
                mv[1] = 1'b1; ma[1] = req1_addr; md[1] = req1_data; mseq[1] = seq_ctr; seq_ctr++;
            end
        end
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_advance();
        #1;
        model_eval();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_addr = '0; req1_addr = '0; req0_data = '0; req1_data = '0;
        cycle(); cycle();
        rst = 1'b0;
        #1;
        n_checks++;
        if ({WE3, A3, WD3, pend_mask, busy, req0_ready, req1_ready} !== {1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state: got we=%b a3=%0d wd3=%h pend=%h busy=%b rdy=%b%b, expected 0/0/0/0/0/11",
                     WE3, A3, WD3, pend_mask, busy, req0_ready, req1_ready);
        end
    endtask

    task automatic test_single();
        apply_reset();
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'h55;
        n_checks++;
        if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b expected 1", req0_ready); end
        cycle();
        req0_valid = 1'b0;
        n_checks++;
        if ({WE3, A3, WD3, pend_mask, busy} !== {1'b1, 5'd5, 32'h55, 32'h20, 1'b1}) begin
            n_fail++;
            $display("FAIL single_write: got we=%b a3=%0d wd3=%h pend=%h busy=%b expected 1/5/55/20/1", WE3, A3, WD3, pend_mask, busy);
        end
        cycle();
        n_checks++;
        if ({WE3, pend_mask, busy} !== {1'b0, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL single_idle: got we=%b pend=%h busy=%b expected 0/0/0", WE3, pend_mask, busy);
        end
    endtask

    task automatic test_contest();
        apply_reset();
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'hA;
        req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'hB;
        cycle();
        req1_valid = 1'b0;
        n_checks++;
        if ({WE3, A3, WD3, pend_mask, req1_ready} !== {1'b1, 5'd3, 32'hA, 32'h18, 1'b0}) begin
            n_fail++;
            $display("FAIL contest_first: got we=%b a3=%0d wd3=%h pend=%h rdy1=%b expected 1/3/a/18/0", WE3, A3, WD3, pend_mask, req1_ready);
        end
        // req0 reloads while draining; round-robin now favours req1
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'hC;
        cycle();
        req0_valid = 1'b0;
        n_checks++;
        if ({WE3, A3, WD3, req0_ready} !== {1'b1, 5'd4, 32'hB, 1'b0}) begin
            n_fail++;
            $display("FAIL contest_rr: got we=%b a3=%0d wd3=%h rdy0=%b expected 1/4/b/0", WE3, A3, WD3, req0_ready);
        end
        cycle();
        n_checks++;
        if ({WE3, A3, WD3} !== {1'b1, 5'd3, 32'hC}) begin
            n_fail++;
            $display("FAIL contest_third: got we=%b a3=%0d wd3=%h expected 1/3/c", WE3, A3, WD3);
        end
        cycle();
        n_checks++;
        if (WE3 !== 1'b0) begin n_fail++; $display("FAIL contest_done: got we=%b expected 0", WE3); end
    endtask

    task automatic test_same_addr();
        apply_reset();
        req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'h1;
        cycle();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h2;
        n_checks++;
        if ({WE3, A3, WD3, req0_ready} !== {1'b1, 5'd7, 32'h1, 1'b1}) begin
            n_fail++;
            $display("FAIL order_first: got we=%b a3=%0d wd3=%h rdy0=%b expected 1/7/1/1", WE3, A3, WD3, req0_ready);
        end
        cycle();
        req0_valid = 1'b0;
        n_checks++;
        if ({WE3, A3, WD3} !== {1'b1, 5'd7, 32'h2}) begin
            n_fail++;
            $display("FAIL order_second: got we=%b a3=%0d wd3=%h expected 1/7/2", WE3, A3, WD3);
        end
        cycle();
        // last grant was req0, so round-robin would pick req1; age must override
        req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h90;
        req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'h91;
        cycle();
        req0_valid = 1'b0; req1_valid = 1'b0;
        n_checks++;
        if ({WE3, A3, WD3, pend_mask} !== {1'b1, 5'd9, 32'h90, 32'h200}) begin
            n_fail++;
            $display("FAIL age_first: got we=%b a3=%0d wd3=%h pend=%h expected 1/9/90/200", WE3, A3, WD3, pend_mask);
        end
        cycle();
        n_checks++;
        if ({WE3, A3, WD3} !== {1'b1, 5'd9, 32'h91}) begin
            n_fail++;
            $display("FAIL age_second: got we=%b a3=%0d wd3=%h expected 1/9/91", WE3, A3, WD3);
        end
        cycle();
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int i = 1; i <= 9; i++) begin
            if (i <= 8) begin
                req0_valid = 1'b1; req0_addr = AW'(i); req0_data = DW'(i);
                n_checks++;
                if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready[%0d]: got %b expected 1", i, req0_ready); end
            end else begin
                req0_valid = 1'b0;
            end
            if (i >= 2) begin
                n_checks++;
                if ({WE3, A3, WD3} !== {1'b1, AW'(i - 1), DW'(i - 1)}) begin
                    n_fail++;
                    $display("FAIL stream_write[%0d]: got we=%b a3=%0d wd3=%h expected 1/%0d/%0h", i, WE3, A3, WD3, i - 1, i - 1);
                end
            end
            cycle();
        end
        n_checks++;
        if (WE3 !== 1'b0) begin n_fail++; $display("FAIL stream_end: got we=%b expected 0", WE3); end
    endtask

    task automatic test_x0();
        apply_reset();
        req0_valid = 1'b1; req0_addr = 5'd0; req0_data = 32'hDEAD;
        n_checks++;
        if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready: got %b expected 1", req0_ready); end
        cycle();
        req0_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({WE3, busy, pend_mask} !== {1'b0, 1'b0, 32'h0}) begin
                n_fail++;
                $display("FAIL x0_nowrite[%0d]: got we=%b busy=%b pend=%h expected 0/0/0", i, WE3, busy, pend_mask);
            end
            cycle();
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h33;
        req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h44;
        cycle();
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++;
        if (WE3 !== 1'b0) begin n_fail++; $display("FAIL midrst_during: got we=%b expected 0", WE3); end
        cycle();
        rst = 1'b0;
        n_checks++;
        if ({WE3, pend_mask, busy, req0_ready, req1_ready} !== {1'b0, 32'h0, 1'b0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL midrst_after: got we=%b pend=%h busy=%b rdy=%b%b expected 0/0/0/11", WE3, pend_mask, busy, req0_ready, req1_ready);
        end
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_checks++;
            if (WE3 !== 1'b0) begin n_fail++; $display("FAIL midrst_nowrite[%0d]: got we=%b expected 0", i, WE3); end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            if (!(req0_valid && !acc0)) begin
                if ($urandom_range(0, 9) < 6) begin
                    req0_valid = 1'b1; req0_addr = AW'($urandom_range(0, 7)); req0_data = $urandom;
                end else req0_valid = 1'b0;
            end
            if (!(req1_valid && !acc1)) begin
                if ($urandom_range(0, 9) < 6) begin
                    req1_valid = 1'b1; req1_addr = AW'($urandom_range(0, 7)); req1_data = $urandom;
                end else req1_valid = 1'b0;
            end
            n_checks++;
            if ({WE3, A3, WD3, pend_mask, busy, req0_ready, req1_ready} !==
                {e_we, e_a3, e_wd3, e_pend, e_busy, e_rdy[0], e_rdy[1]}) begin
                n_fail++;
                $display("FAIL random[%0d]: got we=%b a3=%0d wd3=%h pend=%h busy=%b rdy=%b%b expected %b/%0d/%h/%h/%b/%b%b",
                         c, WE3, A3, WD3, pend_mask, busy, req0_ready, req1_ready,
                         e_we, e_a3, e_wd3, e_pend, e_busy, e_rdy[0], e_rdy[1]);
            end
            cycle();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        cycle(); cycle(); cycle();
    endtask

`ifdef REGFILE_WB_STATS_EN
    task automatic test_stats();
        stats_clr = 1'b0;
        apply_reset();
        n_checks++;
        if (conflict_cnt !== 16'd0) begin n_fail++; $display("FAIL stats_reset: got %0d expected 0", conflict_cnt); end
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h1;
        req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h2;
        cycle();
        req1_valid = 1'b0;
        req0_addr = 5'd5; req0_data = 32'h3;
        cycle();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_addr = 5'd6; req1_data = 32'h4;
        cycle();
        req1_valid = 1'b0;
        cycle(); cycle(); cycle();
        n_checks++;
        if (conflict_cnt !== 16'd3) begin n_fail++; $display("FAIL stats_count: got %0d expected 3", conflict_cnt); end
        stats_clr = 1'b1;
        cycle();
        stats_clr = 1'b0;
        n_checks++;
        if (conflict_cnt !== 16'd0) begin n_fail++; $display("FAIL stats_clear: got %0d expected 0", conflict_cnt); end
    endtask
`endif

    initial begin
        acc0 = 1'b0; acc1 = 1'b0;
        mv[0] = 1'b0; mv[1] = 1'b0; mlast = 1'b1; seq_ctr = 0;
`ifdef REGFILE_WB_STATS_EN
        stats_clr = 1'b0;
`endif
        test_reset();
        test_single();
        test_contest();
        test_same_addr();
        test_back_to_back();
        test_x0();
        test_reset_mid();
        test_random();
`ifdef REGFILE_WB_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
